// File: rtl/miner_regs_pkg.sv
// Shared constants for the mining-core register bank: register offsets,
// CTRL/STATUS bit positions, fixed read values and the access FSM states.
package miner_regs_pkg;

    // Byte offsets of the scalar registers.
    localparam logic [7:0] OFF_CTRL        = 8'h00;
    localparam logic [7:0] OFF_STATUS      = 8'h04;
    localparam logic [7:0] OFF_NONCE_START = 8'h08;
    localparam logic [7:0] OFF_NONCE_END   = 8'h0C;
    localparam logic [7:0] OFF_FOUND_NONCE = 8'h10;
    localparam logic [7:0] OFF_CYCLE_CNT   = 8'h14;
    localparam logic [7:0] OFF_VERSION     = 8'h18;
    // Base offsets of the word arrays (consecutive 32-bit words).
    localparam logic [7:0] OFF_MIDSTATE0   = 8'h20;
    localparam logic [7:0] OFF_TAIL0       = 8'h40;

    localparam int NUM_MIDSTATE = 8;
    localparam int NUM_TAIL     = 3;

    // CTRL bits.
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_ABORT_BIT  = 2;

    // STATUS bits.
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;
    localparam int STATUS_FOUND_BIT = 2;

    localparam logic [31:0] VERSION_VALUE  = 32'h534D_0001;
    localparam logic [31:0] UNMAPPED_VALUE = 32'hDEAD_BEEF;

    // Access FSM: one access per addr_valid assertion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_WAIT = 2'd2
    } acc_state_e;

    // Word index used by the decoder (reg_addr[7:2]).
    function automatic logic [5:0] word_idx(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/miner_regbank_if.sv
// Regbus link between the AXI4-Lite bridge (master) and the register bank (slave).
interface miner_regbank_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              addr_valid;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_ready;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        output addr_valid, reg_write, reg_addr, reg_wdata,
        input  reg_ready, reg_rdata
    );

    modport slave (
        input  addr_valid, reg_write, reg_addr, reg_wdata,
        output reg_ready, reg_rdata
    );
endinterface

// File: rtl/miner_regbank.sv
// Control/status register bank for the mining core: decodes regbus accesses,
// holds the job descriptor, pulses Start/Abort and captures engine status.
// Only DATA_W = 32 is supported.
module miner_regbank
    import miner_regs_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    miner_regbank_if.slave        regbus_if,
    output logic [255:0]          Midstate,
    output logic [95:0]           Data_tail,
    output logic [31:0]           Nonce_start,
    output logic [31:0]           Nonce_end,
    output logic                  Start,
    output logic                  Abort,
    input  logic                  Busy,
    input  logic                  Done,
    input  logic                  Found,
    input  logic [31:0]           Found_nonce,
    output logic                  Irq
);

    localparam logic [5:0] IDX_CTRL        = word_idx(OFF_CTRL);
    localparam logic [5:0] IDX_STATUS      = word_idx(OFF_STATUS);
    localparam logic [5:0] IDX_NONCE_START = word_idx(OFF_NONCE_START);
    localparam logic [5:0] IDX_NONCE_END   = word_idx(OFF_NONCE_END);
    localparam logic [5:0] IDX_FOUND_NONCE = word_idx(OFF_FOUND_NONCE);
    localparam logic [5:0] IDX_CYCLE_CNT   = word_idx(OFF_CYCLE_CNT);
    localparam logic [5:0] IDX_VERSION     = word_idx(OFF_VERSION);
    localparam logic [5:0] IDX_MIDSTATE0   = word_idx(OFF_MIDSTATE0);
    localparam logic [5:0] IDX_TAIL0       = word_idx(OFF_TAIL0);

    // ---------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------
    acc_state_e        state_q, state_d;
    logic              access;
    logic              wr_en;
    logic              rd_en;
    logic [5:0]        idx;
    logic [DATA_W-1:0] wdata;
    logic              unused_addr;

    // Only word index bits take part in decode; the rest alias.
    assign unused_addr = ^{regbus_if.reg_addr[ADDR_W-1:8], regbus_if.reg_addr[1:0]};
    assign idx    = regbus_if.reg_addr[7:2];
    assign wdata  = regbus_if.reg_wdata;
    assign access = (state_q == ST_IDLE) && regbus_if.addr_valid;
    assign wr_en  = access &&  regbus_if.reg_write;
    assign rd_en  = access && !regbus_if.reg_write;

    // ---------------------------------------------------------------
    // Register state
    // ---------------------------------------------------------------
    logic              irq_en_q;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [31:0]       found_nonce_q;
    logic [31:0]       cycle_cnt_q;
    logic [31:0]       nonce_start_q;
    logic [31:0]       nonce_end_q;
    logic [31:0]       midstate_q [NUM_MIDSTATE];
    logic [31:0]       tail_q     [NUM_TAIL];
    logic              start_q, start_d;
    logic              abort_q, abort_d;
    logic              irq_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ctrl_wr;
    logic              status_wr;

    assign ctrl_wr   = wr_en && (idx == IDX_CTRL);
    assign status_wr = wr_en && (idx == IDX_STATUS);

    // ---------------------------------------------------------------
    // Access FSM
    // ---------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: serve once, then wait for addr_valid to drop.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (regbus_if.addr_valid)  state_d = ST_RESP;
            ST_RESP:                            state_d = ST_WAIT;
            ST_WAIT: if (!regbus_if.addr_valid) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: acknowledge for the single RESP cycle.
    always_comb begin
        regbus_if.reg_ready = (state_q == ST_RESP);
    end

    assign regbus_if.reg_rdata = rdata_q;

    // ---------------------------------------------------------------
    // Control and status next-state
    // ---------------------------------------------------------------

    // Pulse requests and sticky flags; ABORT beats START, a START during Busy is dropped,
    // and an engine pulse beats a simultaneous write-1-to-clear.
    always_comb begin
        abort_d = ctrl_wr && wdata[CTRL_ABORT_BIT];
        start_d = ctrl_wr && wdata[CTRL_START_BIT] && !wdata[CTRL_ABORT_BIT] && !Busy;
        done_d  = Done  || (done_q  && !(status_wr && wdata[STATUS_DONE_BIT]));
        found_d = Found || (found_q && !(status_wr && wdata[STATUS_FOUND_BIT]));
    end

    // Control, status, counter and interrupt registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            irq_en_q      <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            cycle_cnt_q   <= '0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            start_q <= start_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            found_q <= found_d;
            if (ctrl_wr) irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
            // First hit wins until software clears FOUND.
            if (Found && !found_q) found_nonce_q <= Found_nonce;
            // Clear on the Start pulse takes priority over counting.
            if (start_q)                          cycle_cnt_q <= '0;
            else if (Busy && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            irq_q <= irq_en_q && (done_q || found_q);
        end
    end

    // Job descriptor registers (nonce range, midstate, header tail).
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            nonce_start_q <= '0;
            nonce_end_q   <= '0;
            // NOTE: these arrays drive outputs that must be 0 out of reset, so they are plain reset flops, not RAM.
            for (int i = 0; i < NUM_MIDSTATE; i++) midstate_q[i] <= '0;
            for (int i = 0; i < NUM_TAIL; i++)     tail_q[i]     <= '0;
        end else if (wr_en) begin
            if (idx == IDX_NONCE_START) nonce_start_q <= wdata;
            if (idx == IDX_NONCE_END)   nonce_end_q   <= wdata;
            for (int i = 0; i < NUM_MIDSTATE; i++)
                if (idx == 6'(IDX_MIDSTATE0 + i)) midstate_q[i] <= wdata;
            for (int i = 0; i < NUM_TAIL; i++)
                if (idx == 6'(IDX_TAIL0 + i)) tail_q[i] <= wdata;
        end
    end

    // ---------------------------------------------------------------
    // Read path
    // ---------------------------------------------------------------

    // Read mux; unmapped words return a recognisable marker.
    always_comb begin
        rdata_d = UNMAPPED_VALUE;
        case (idx)
            IDX_CTRL:        rdata_d = {29'd0, 1'b0, irq_en_q, 1'b0};
            IDX_STATUS:      rdata_d = {29'd0, found_q, done_q, Busy};
            IDX_NONCE_START: rdata_d = nonce_start_q;
            IDX_NONCE_END:   rdata_d = nonce_end_q;
            IDX_FOUND_NONCE: rdata_d = found_nonce_q;
            IDX_CYCLE_CNT:   rdata_d = cycle_cnt_q;
            IDX_VERSION:     rdata_d = VERSION_VALUE;
            default:         rdata_d = UNMAPPED_VALUE;
        endcase
        for (int i = 0; i < NUM_MIDSTATE; i++)
            if (idx == 6'(IDX_MIDSTATE0 + i)) rdata_d = midstate_q[i];
        for (int i = 0; i < NUM_TAIL; i++)
            if (idx == 6'(IDX_TAIL0 + i)) rdata_d = tail_q[i];
    end

    // Read data register: updated only by reads, held across writes.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)     rdata_q <= '0;
        else if (rd_en) rdata_q <= rdata_d;
    end

    // ---------------------------------------------------------------
    // Output wiring
    // ---------------------------------------------------------------
    for (genvar g = 0; g < NUM_MIDSTATE; g++) begin : g_midstate
        assign Midstate[32*g +: 32] = midstate_q[g];
    end

    for (genvar g = 0; g < NUM_TAIL; g++) begin : g_tail
        assign Data_tail[32*g +: 32] = tail_q[g];
    end

    assign Nonce_start = nonce_start_q;
    assign Nonce_end   = nonce_end_q;
    assign Start       = start_q;
    assign Abort       = abort_q;
    assign Irq         = irq_q;

endmodule

// File: tb/tb_miner_regbank.sv
// Directed self-checking bench for miner_regbank.
module tb_miner_regbank;

    logic        Clk;
    logic        Rst_n;
    logic [255:0] Midstate;
    logic [95:0]  Data_tail;
    logic [31:0]  Nonce_start;
    logic [31:0]  Nonce_end;
    logic         Start;
    logic         Abort;
    logic         Busy;
    logic         Done;
    logic         Found;
    logic [31:0]  Found_nonce;
    logic         Irq;

    int errors = 0;
    int checks = 0;

    // Values captured by bus_write in the response cycle (p1) and the cycle after (p2).
    logic start_p1, start_p2, abort_p1, abort_p2, irq_p1, irq_p2;

    miner_regbank_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    miner_regbank #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .regbus_if   (bus),
        .Midstate    (Midstate),
        .Data_tail   (Data_tail),
        .Nonce_start (Nonce_start),
        .Nonce_end   (Nonce_end),
        .Start       (Start),
        .Abort       (Abort),
        .Busy        (Busy),
        .Done        (Done),
        .Found       (Found),
        .Found_nonce (Found_nonce),
        .Irq         (Irq)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One write access; Done/Found can be pulsed on the sampling edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input bit done_p = 1'b0, input bit found_p = 1'b0);
        @(negedge Clk);
        bus.addr_valid = 1'b1;
        bus.reg_write  = 1'b1;
        bus.reg_addr   = addr;
        bus.reg_wdata  = data;
        if (done_p)  Done  = 1'b1;
        if (found_p) Found = 1'b1;
        @(negedge Clk);
        check("wr_ready", {255'd0, bus.reg_ready}, 256'd1);
        start_p1 = Start; abort_p1 = Abort; irq_p1 = Irq;
        bus.addr_valid = 1'b0;
        Done  = 1'b0;
        Found = 1'b0;
        @(negedge Clk);
        check("wr_ready_low", {255'd0, bus.reg_ready}, 256'd0);
        start_p2 = Start; abort_p2 = Abort; irq_p2 = Irq;
    endtask

    // One read access; returns the data presented with reg_ready.
    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge Clk);
        bus.addr_valid = 1'b1;
        bus.reg_write  = 1'b0;
        bus.reg_addr   = addr;
        bus.reg_wdata  = 32'h0;
        @(negedge Clk);
        check("rd_ready", {255'd0, bus.reg_ready}, 256'd1);
        data = bus.reg_rdata;
        bus.addr_valid = 1'b0;
        @(negedge Clk);
        check("rd_ready_low", {255'd0, bus.reg_ready}, 256'd0);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, {224'd0, d}, {224'd0, expected});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},    {255'd0, bus.reg_ready}, 256'd0);
        check({tag, "_rdata"},    {224'd0, bus.reg_rdata}, 256'd0);
        check({tag, "_midstate"}, Midstate, 256'd0);
        check({tag, "_tail"},     {160'd0, Data_tail}, 256'd0);
        check({tag, "_nstart"},   {224'd0, Nonce_start}, 256'd0);
        check({tag, "_nend"},     {224'd0, Nonce_end}, 256'd0);
        check({tag, "_start"},    {255'd0, Start}, 256'd0);
        check({tag, "_abort"},    {255'd0, Abort}, 256'd0);
        check({tag, "_irq"},      {255'd0, Irq}, 256'd0);
    endtask

    initial begin
        logic [31:0]  d;
        logic [255:0] mid_exp;
        int           ready_cnt;

        Rst_n          = 1'b0;
        Busy           = 1'b0;
        Done           = 1'b0;
        Found          = 1'b0;
        Found_nonce    = 32'h0;
        bus.addr_valid = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_addr   = 32'h0;
        bus.reg_wdata  = 32'h0;

        // Reset state.
        repeat (3) @(negedge Clk);
        check_outputs_zero("in_reset");
        Rst_n = 1'b1;
        @(negedge Clk);
        check_outputs_zero("after_reset");

        // VERSION read, and a held addr_valid served only once.
        read_check("version", 32'h0000_0018, 32'h534D_0001);
        @(negedge Clk);
        bus.addr_valid = 1'b1;
        bus.reg_write  = 1'b0;
        bus.reg_addr   = 32'h0000_0018;
        ready_cnt = 0;
        repeat (5) begin
            @(negedge Clk);
            if (bus.reg_ready === 1'b1) ready_cnt++;
        end
        check("held_valid_single_ready", 256'(ready_cnt), 256'd1);
        bus.addr_valid = 1'b0;
        @(negedge Clk);

        // Midstate write/read-back and output packing.
        for (int i = 0; i < 8; i++) bus_write(32'h20 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
        for (int i = 0; i < 8; i++) read_check("midstate_rb", 32'h20 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
        mid_exp = '0;
        for (int i = 0; i < 8; i++) mid_exp[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
        check("midstate_lo", {224'd0, Midstate[31:0]}, {224'd0, 32'h1111_1111});
        check("midstate_hi", {224'd0, Midstate[255:224]}, {224'd0, 32'h8888_8888});
        check("midstate_all", Midstate, mid_exp);

        // Tail and nonce range.
        bus_write(32'h40, 32'hA000_0000);
        bus_write(32'h44, 32'hB000_0001);
        bus_write(32'h48, 32'hC000_0002);
        bus_write(32'h08, 32'h0000_0100);
        bus_write(32'h0C, 32'h0000_01FF);
        check("data_tail", {160'd0, Data_tail}, {160'd0, 96'hC000_0002_B000_0001_A000_0000});
        check("nonce_start", {224'd0, Nonce_start}, {224'd0, 32'h0000_0100});
        check("nonce_end", {224'd0, Nonce_end}, {224'd0, 32'h0000_01FF});
        read_check("tail2_rb", 32'h48, 32'hC000_0002);

        // Start pulse with Busy=0, one cycle wide.
        bus_write(32'h00, 32'h1);
        check("start_pulse", {255'd0, start_p1}, 256'd1);
        check("start_one_cycle", {255'd0, start_p2}, 256'd0);
        check("no_abort_on_start", {255'd0, abort_p1}, 256'd0);

        // Ten busy cycles counted.
        @(negedge Clk);
        Busy = 1'b1;
        repeat (10) @(negedge Clk);
        Busy = 1'b0;
        read_check("cycle_cnt_10", 32'h14, 32'd10);

        // A new Start clears the counter.
        bus_write(32'h00, 32'h1);
        check("start_pulse_2", {255'd0, start_p1}, 256'd1);
        read_check("cycle_cnt_cleared", 32'h14, 32'd0);

        // START while busy is ignored.
        Busy = 1'b1;
        bus_write(32'h00, 32'h1);
        check("start_ignored_busy", {255'd0, start_p1}, 256'd0);
        Busy = 1'b0;

        // START+ABORT together: ABORT only; ABORT reads back as 0.
        bus_write(32'h00, 32'h5);
        check("abort_pulse", {255'd0, abort_p1}, 256'd1);
        check("abort_one_cycle", {255'd0, abort_p2}, 256'd0);
        check("abort_beats_start", {255'd0, start_p1}, 256'd0);
        read_check("ctrl_after_abort", 32'h00, 32'h0);

        // IRQ_EN and first-hit-wins FOUND_NONCE.
        bus_write(32'h00, 32'h2);
        read_check("ctrl_irq_en", 32'h00, 32'h2);
        @(negedge Clk);
        Found = 1'b1; Found_nonce = 32'hCAFE_F00D;
        @(negedge Clk);
        Found = 1'b0; Found_nonce = 32'h0;
        @(negedge Clk);
        Found = 1'b1; Found_nonce = 32'h1234_5678;
        @(negedge Clk);
        Found = 1'b0; Found_nonce = 32'h0;
        read_check("found_nonce_first", 32'h10, 32'hCAFE_F00D);
        check("irq_on_found", {255'd0, Irq}, 256'd1);
        read_check("status_found", 32'h04, 32'h4);

        // W1C FOUND: flag clears immediately, Irq one cycle later.
        bus_write(32'h04, 32'h4);
        check("irq_still_high", {255'd0, irq_p1}, 256'd1);
        check("irq_dropped", {255'd0, irq_p2}, 256'd0);
        read_check("status_cleared", 32'h04, 32'h0);

        // Read data holds across writes.
        read_check("version_again", 32'h18, 32'h534D_0001);
        bus_write(32'h08, 32'h0000_0200);
        check("rdata_held_on_write", {224'd0, bus.reg_rdata}, {224'd0, 32'h534D_0001});

        // DONE set, then W1C with a coincident Done pulse: set wins.
        @(negedge Clk);
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
        read_check("status_done", 32'h04, 32'h2);
        bus_write(32'h04, 32'h2, 1'b1, 1'b0);
        read_check("done_set_wins", 32'h04, 32'h2);
        bus_write(32'h04, 32'h2);
        read_check("done_cleared", 32'h04, 32'h0);

        // Found and Done together set both; FOUND_NONCE re-arms after the clear.
        Found_nonce = 32'hA5A5_A5A5;
        bus_write(32'h1C, 32'h0, 1'b1, 1'b1);
        Found_nonce = 32'h0;
        read_check("status_both", 32'h04, 32'h6);
        read_check("found_nonce_rearm", 32'h10, 32'hA5A5_A5A5);

        // Unmapped read, aliasing, read-only VERSION.
        read_check("unmapped", 32'h7C, 32'hDEAD_BEEF);
        read_check("alias_version", 32'h1000_0018, 32'h534D_0001);
        bus_write(32'h18, 32'h0);
        read_check("version_ro", 32'h18, 32'h534D_0001);
        read_check("live_busy_status", 32'h04, 32'h6);

        // Reset asserted during the RESP cycle.
        @(negedge Clk);
        bus.addr_valid = 1'b1;
        bus.reg_write  = 1'b0;
        bus.reg_addr   = 32'h08;
        @(posedge Clk);
        #1 Rst_n = 1'b0;
        @(negedge Clk);
        check_outputs_zero("mid_access_reset");
        bus.addr_valid = 1'b0;
        @(negedge Clk);
        check("no_ready_in_reset", {255'd0, bus.reg_ready}, 256'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("no_ready_after_reset", {255'd0, bus.reg_ready}, 256'd0);
        read_check("ctrl_reset", 32'h00, 32'h0);
        read_check("status_reset", 32'h04, 32'h0);
        read_check("found_nonce_reset", 32'h10, 32'h0);
        read_check("cycle_cnt_reset", 32'h14, 32'h0);
        read_check("nonce_start_reset", 32'h08, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
